// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the data-memory load/store unit.
//   - request size encoding
//   - FSM state encoding (plain constants so older tools can consume them)
//   - data memory size
// -----------------------------------------------------------------------------
package lsu_pkg;

   localparam int LSU_MEM_BYTES = 1024;

   // request size encoding
   localparam logic LSU_SIZE_BYTE = 1'b0;
   localparam logic LSU_SIZE_WORD = 1'b1;

   // FSM state encoding
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RD   = 2'd1;
   localparam logic [1:0] S_RD2  = 2'd2;
   localparam logic [1:0] S_WR2  = 2'd3;

endpackage : lsu_pkg

// File: rtl/lsu_load_align.sv
// -----------------------------------------------------------------------------
// lsu_load_align
// Combinational load formatter. Picks the byte lane selected by the byte
// address LSB (big-endian: even -> high lane, odd -> low lane) and zero- or
// sign-extends it, or passes the whole word through for word loads.
// Ports:
//   i_dout_h, i_dout_l : BRAM read lanes
//   i_addr0            : byte address bit 0
//   i_size             : LSU_SIZE_BYTE / LSU_SIZE_WORD
//   i_signed           : sign-extend byte loads
//   o_data             : 16-bit load result
// -----------------------------------------------------------------------------
module lsu_load_align
   import lsu_pkg::*;
(
   input  logic [7:0]  i_dout_h,
   input  logic [7:0]  i_dout_l,
   input  logic        i_addr0,
   input  logic        i_size,
   input  logic        i_signed,
   output logic [15:0] o_data
);

   logic [7:0]  lane_s;
   logic [15:0] data_s;

   // lane select and extension
   always_comb begin
      lane_s = 8'h00;
      data_s = 16'h0000;
      if (i_addr0) begin
         lane_s = i_dout_l;
      end else begin
         lane_s = i_dout_h;
      end
      if (i_size == LSU_SIZE_WORD) begin
         data_s = {i_dout_h, i_dout_l};
      end else if (i_signed) begin
         data_s = {{8{lane_s[7]}}, lane_s};
      end else begin
         data_s = {8'h00, lane_s};
      end
   end

   assign o_data = data_s;

endmodule : lsu_load_align

// File: rtl/data_mem_lsu.sv
// -----------------------------------------------------------------------------
// data_mem_lsu
// Load/store unit between the execute stage and BRAM port B (1 KB, two byte
// lanes, big-endian). One request at a time over valid/ready; responses are a
// single-cycle pulse with no backpressure.
// Configuration macro: LSU_MISALIGN_EN -- when defined, odd-address word
// accesses are split into two BRAM accesses (states S_RD2/S_WR2); otherwise
// they are rejected with o_rsp_err.
// Ports:
//   i_clk, i_rst_n          : clock, async active-low reset
//   i_req_* / o_req_ready   : request channel (accepted on valid & ready)
//   o_rsp_valid/rdata/err   : response pulse
//   o_b_*                   : BRAM port-B enable, lane write enables, word
//                             address and write lanes
//   i_b_dout_h/l            : BRAM read lanes (valid the cycle after enable)
// -----------------------------------------------------------------------------
module data_mem_lsu
   import lsu_pkg::*;
#(
   parameter int ADDR_W = $clog2(LSU_MEM_BYTES)
)
(
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_req_valid,
   output logic              o_req_ready,
   input  logic              i_req_we,
   input  logic              i_req_size,
   input  logic              i_req_signed,
   input  logic [15:0]       i_req_addr,
   input  logic [15:0]       i_req_wdata,
   output logic              o_rsp_valid,
   output logic [15:0]       o_rsp_rdata,
   output logic              o_rsp_err,
   output logic              o_b_en,
   output logic              o_b_we_h,
   output logic              o_b_we_l,
   output logic [ADDR_W-2:0] o_b_addr,
   output logic [7:0]        o_b_din_h,
   output logic [7:0]        o_b_din_l,
   input  logic [7:0]        i_b_dout_h,
   input  logic [7:0]        i_b_dout_l
);

   logic [1:0]  state_r;
   logic        run_r;
   logic        rsp_valid_r;
   logic        rsp_err_r;
   logic [15:0] rsp_rdata_r;
   logic        req_addr0_r;
   logic        req_size_r;
   logic        req_signed_r;

`ifdef LSU_MISALIGN_EN
   localparam logic [ADDR_W-2:0] WADDR_ONE = {{(ADDR_W-2){1'b0}}, 1'b1};
   logic [ADDR_W-2:0] req_waddr_r;
   logic [7:0]        req_wlo_r;
   logic [7:0]        hi_byte_r;
`endif

   logic              ready_s;
   logic              accept_s;
   logic              range_err_s;
   logic              misalign_s;
   logic              req_err_s;
   logic              b_en_s;
   logic              b_we_h_s;
   logic              b_we_l_s;
   logic [ADDR_W-2:0] b_addr_s;
   logic [7:0]        b_din_h_s;
   logic [7:0]        b_din_l_s;
   logic [15:0]       align_s;

   assign ready_s     = run_r && (state_r == S_IDLE);
   assign accept_s    = i_req_valid && ready_s;
   assign range_err_s = ((i_req_addr >> ADDR_W) != 16'h0000);
   assign misalign_s  = (i_req_size == LSU_SIZE_WORD) && i_req_addr[0];
`ifdef LSU_MISALIGN_EN
   assign req_err_s   = range_err_s;
`else
   assign req_err_s   = range_err_s || misalign_s;
`endif

   lsu_load_align u_align (
      .i_dout_h (i_b_dout_h),
      .i_dout_l (i_b_dout_l),
      .i_addr0  (req_addr0_r),
      .i_size   (req_size_r),
      .i_signed (req_signed_r),
      .o_data   (align_s)
   );

   // port-B drive: straight from the request in S_IDLE so the access lands on
   // the accept edge, from captured state for the second half of a split
   always_comb begin
      b_en_s    = 1'b0;
      b_we_h_s  = 1'b0;
      b_we_l_s  = 1'b0;
      b_addr_s  = i_req_addr[ADDR_W-1:1];
      b_din_h_s = i_req_wdata[7:0];
      b_din_l_s = i_req_wdata[7:0];
      case (state_r)
         S_IDLE: begin
            if (accept_s && !req_err_s) begin
               b_en_s = 1'b1;
               if (!i_req_we) begin
                  b_we_h_s = 1'b0;
               end else if (i_req_size == LSU_SIZE_BYTE) begin
                  b_we_h_s = !i_req_addr[0];
                  b_we_l_s = i_req_addr[0];
               end else if (misalign_s) begin
                  // first half of a split store: high byte goes to low lane of w
                  b_we_l_s  = 1'b1;
                  b_din_l_s = i_req_wdata[15:8];
               end else begin
                  b_we_h_s  = 1'b1;
                  b_we_l_s  = 1'b1;
                  b_din_h_s = i_req_wdata[15:8];
               end
            end else begin
               b_en_s = 1'b0;
            end
         end
`ifdef LSU_MISALIGN_EN
         S_RD: begin
            // split load: fetch w+1 while the first word's data is captured
            if ((req_size_r == LSU_SIZE_WORD) && req_addr0_r) begin
               b_en_s   = 1'b1;
               b_addr_s = req_waddr_r + WADDR_ONE;
            end else begin
               b_en_s = 1'b0;
            end
         end
         S_WR2: begin
            b_en_s    = 1'b1;
            b_we_h_s  = 1'b1;
            b_addr_s  = req_waddr_r + WADDR_ONE;
            b_din_h_s = req_wlo_r;
            b_din_l_s = req_wlo_r;
         end
`endif
         default: begin
            b_en_s = 1'b0;
         end
      endcase
   end

   // request capture, FSM and registered response
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_r      <= S_IDLE;
         run_r        <= 1'b0;
         rsp_valid_r  <= 1'b0;
         rsp_err_r    <= 1'b0;
         rsp_rdata_r  <= 16'h0000;
         req_addr0_r  <= 1'b0;
         req_size_r   <= 1'b0;
         req_signed_r <= 1'b0;
`ifdef LSU_MISALIGN_EN
         req_waddr_r  <= '0;
         req_wlo_r    <= 8'h00;
         hi_byte_r    <= 8'h00;
`endif
      end else begin
         run_r       <= 1'b1;
         rsp_valid_r <= 1'b0;
         rsp_err_r   <= 1'b0;
         rsp_rdata_r <= 16'h0000;
         case (state_r)
            S_IDLE: begin
               if (accept_s) begin
                  req_addr0_r  <= i_req_addr[0];
                  req_size_r   <= i_req_size;
                  req_signed_r <= i_req_signed;
`ifdef LSU_MISALIGN_EN
                  req_waddr_r  <= i_req_addr[ADDR_W-1:1];
                  req_wlo_r    <= i_req_wdata[7:0];
`endif
                  if (req_err_s) begin
                     rsp_valid_r <= 1'b1;
                     rsp_err_r   <= 1'b1;
                  end else if (!i_req_we) begin
                     state_r <= S_RD;
`ifdef LSU_MISALIGN_EN
                  end else if (misalign_s) begin
                     state_r <= S_WR2;
`endif
                  end else begin
                     rsp_valid_r <= 1'b1;
                  end
               end
            end
            S_RD: begin
`ifdef LSU_MISALIGN_EN
               if ((req_size_r == LSU_SIZE_WORD) && req_addr0_r) begin
                  hi_byte_r <= i_b_dout_l;
                  state_r   <= S_RD2;
               end else begin
                  rsp_valid_r <= 1'b1;
                  rsp_rdata_r <= align_s;
                  state_r     <= S_IDLE;
               end
`else
               rsp_valid_r <= 1'b1;
               rsp_rdata_r <= align_s;
               state_r     <= S_IDLE;
`endif
            end
`ifdef LSU_MISALIGN_EN
            S_RD2: begin
               rsp_valid_r <= 1'b1;
               rsp_rdata_r <= {hi_byte_r, i_b_dout_h};
               state_r     <= S_IDLE;
            end
            S_WR2: begin
               rsp_valid_r <= 1'b1;
               state_r     <= S_IDLE;
            end
`endif
            default: begin
               state_r <= S_IDLE;
            end
         endcase
      end
   end

   assign o_req_ready = ready_s;
   assign o_rsp_valid = rsp_valid_r;
   assign o_rsp_rdata = rsp_rdata_r;
   assign o_rsp_err   = rsp_err_r;
   assign o_b_en      = run_r && b_en_s;
   assign o_b_we_h    = run_r && b_we_h_s;
   assign o_b_we_l    = run_r && b_we_l_s;
   assign o_b_addr    = b_addr_s;
   assign o_b_din_h   = b_din_h_s;
   assign o_b_din_l   = b_din_l_s;

endmodule : data_mem_lsu

// File: doc/data_mem_lsu.md
# data_mem_lsu

Load/store unit between the core's execute stage and the data port (port B) of the 1 KB dual-port, byte-enabled instruction/data BRAM. It accepts one byte or word request at a time over a valid/ready handshake and drives the BRAM port-B enable, byte write enables, word address and data lanes. It also selects and extends load bytes, and splits misaligned word accesses. Memory is big-endian: even byte address maps to the high lane, odd to the low lane.

## Interface
- ADDR_W, 10: byte-address width of the data memory. Word address is bits [ADDR_W-1:1].
- i_clk  in  1  clock. Single domain.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_req_valid  in  1  request valid.
- o_req_ready  out  1  request accepted when valid and ready are both high (edge E0).
- i_req_we  in  1  1 = store, 0 = load.
- i_req_size  in  1  0 = byte, 1 = word.
- i_req_signed  in  1  sign-extend byte loads. Ignored otherwise.
- i_req_addr  in  16  byte address.
- i_req_wdata  in  16  store data. Byte stores use [7:0].
- o_rsp_valid  out  1  one-cycle response pulse.
- o_rsp_rdata  out  16  load data. 0 for stores and errors.
- o_rsp_err  out  1  qualified by o_rsp_valid.
- o_b_en, o_b_we_h, o_b_we_l  out  1 each  BRAM port-B controls.
- o_b_addr  out  9  BRAM word address.
- o_b_din_h, o_b_din_l  out  8 each  write lanes.
- i_b_dout_h, i_b_dout_l  in  8 each  read lanes. Valid the cycle after the enabled edge.

## Operation
- FSM states:
  - S_IDLE: o_req_ready = 1 once out of reset.
  - S_RD: wait for BRAM data.
  - S_RD2: second half of a misaligned load.
  - S_WR2: second half of a misaligned store.
- While in S_IDLE, port-B outputs are combinational from the request, so the BRAM access happens at the accept edge E0.
- Error check on the request:
  - Out of range: i_req_addr[15:ADDR_W] != 0.
  - Misaligned word when LSU_MISALIGN_EN is undefined.
  - Either case: o_b_en stays 0 and the FSM stays in S_IDLE. Response after E0 with err = 1 and rdata = 0.
- Byte store:
  - Both din lanes = wdata[7:0].
  - we_h if addr[0] = 0, else we_l.
  - Response after E0.
- Aligned word store: din_h = wdata[15:8], din_l = wdata[7:0], both write enables set. Response after E0.
- Byte load:
  - Capture the lane selected by addr[0] in S_RD.
  - Zero- or sign-extend to 16 bits.
  - Response after E1.
- Aligned word load: rdata = {dout_h, dout_l}. Response after E1.
- Misaligned word (odd address), first access at E0 uses word address w = addr[9:1]. The second uses w + 1 mod 512, so 511 wraps to 0.
  - Load: rdata[15:8] = dout_l of w (captured in S_RD), rdata[7:0] = dout_h of w + 1 (captured in S_RD2). Response after E2.
  - Store: E0 writes wdata[15:8] to the low lane of w. E1 (S_WR2) writes wdata[7:0] to the high lane of w + 1. Response after E1.
- Only one request is outstanding. A new request may be accepted in the same cycle o_rsp_valid is high. Responses have no backpressure.

## Timing
- Reset values: state S_IDLE, o_rsp_valid 0, o_rsp_err 0, o_rsp_rdata 0, and internal request registers 0.
- A registered run flag (cleared by reset) gates o_req_ready and o_b_en. While i_rst_n is low, and in the first cycle after release, o_req_ready = 0, o_b_en = 0 and both write enables are 0.
- Latency from accept edge to the edge that raises o_rsp_valid:
  - Store: 1.
  - Misaligned store: 2.
  - Load: 2.
  - Misaligned load: 3.
  - Error: 1.
- Throughput: aligned stores 1 per cycle; aligned loads 1 per 2 cycles.
- Reset asserted mid-operation aborts immediately: no second-half write occurs and no response is issued.
- o_rsp_valid is high for exactly one cycle per accepted request.

## Configuration
- LSU_MISALIGN_EN defined: odd-address word accesses are split into two BRAM accesses as described under Operation, and S_RD2/S_WR2 exist.
- Undefined: odd-address word accesses return o_rsp_err = 1 with no BRAM access, and S_RD2/S_WR2 are not built.

## Structure
- Shared package lsu_pkg:
  - size encoding (LSU_SIZE_BYTE = 0, LSU_SIZE_WORD = 1)
  - FSM state encoding
  - LSU_MEM_BYTES = 1024
- Sub-module lsu_load_align, combinational: inputs lane data, addr[0], size and signed; output the 16-bit extended result.

## Test plan
- Word store 0xBEEF at 0x0010, then word load at 0x0010 → rdata 0xBEEF, err 0. Load response 2 cycles after accept.
- Byte store 0x80 at 0x0021, then signed byte load at 0x0021 → 0xFF80; unsigned load → 0x0080; byte at 0x0020 unchanged.
- Word load at 0x0400 → one-cycle response, err 1, rdata 0, o_b_en never high.
- With LSU_MISALIGN_EN: word store 0x1234 at 0x03FF → low lane of word 511 = 0x12, high lane of word 0 = 0x34. Word load at 0x03FF → 0x1234 after 3 cycles. Without the macro: err 1.
- Four back-to-back aligned word stores with valid held high → ready stays 1 and four acks arrive on consecutive cycles.
- Drop i_rst_n in S_WR2 → no second write, no response, and ready stays low until one cycle after release.
